prog_mem_loader: RTL and testbench

//  Upstream instruction store for the 4-bit CPU: 64 x 8-bit program RAM.
//  - CPU side: combinational fetch, addr -> data.
//  - Host side: byte-stream valid/ready port, framed load with checksum.
//  - Holds the CPU in reset until a valid image has been committed.

---
 rtl/prog_mem_loader.sv | 174 +++++++++++++++++
 tb/tb_prog_mem_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Program RAM for the 4-bit CPU with a framed, checksummed host loader.
// The CPU is held in reset until a complete image passes its checksum.
module prog_mem_loader #(
    parameter int         AW        = 6,
    parameter int         DW        = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] fetch_addr,
    output logic [DW-1:0] fetch_data,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          cpu_run,
    output logic          loaded,
    output logic          load_err
);

    // state  | meaning
    // IDLE   | no image since reset; waiting for a sync byte
    // LOAD   | writing frame bytes into mem[idx], accumulating sum
    // CHECK  | waiting for the checksum byte
    // WAIT   | one-cycle commit gap, host stalled
    // RUN    | image committed, CPU released
    // ERROR  | last frame failed (bad checksum or timeout)

    localparam int             DEPTH    = 1 << AW;
    localparam int             TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW-1:0]  LAST_IDX = {AW{1'b1}};
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_WAIT,
        S_RUN,
        S_ERROR
    } state_t;

    state_t         state;
    logic [AW-1:0]  idx;
    logic [7:0]     sum;
    logic [TW-1:0]  tmo;
    logic [DW-1:0]  mem [0:DEPTH-1];

    logic           accept;
    logic           is_sync;
    logic           write_en;
    logic           timed_out;
    logic [7:0]     sum_next;

    assign in_ready  = (state != S_WAIT);
    assign accept    = in_valid & in_ready;
    assign is_sync   = (in_data == SYNC_BYTE);
    assign sum_next  = sum + in_data;
    assign timed_out = ~accept & (tmo == TMO_LAST);

    // A reset edge must never commit a byte, even with a live handshake.
    assign write_en  = accept & (state == S_LOAD) & ~reset;

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[idx] <= DW'(in_data);
        end
    end

    assign fetch_data = mem[fetch_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cpu_run  <= 1'b0;
            loaded   <= 1'b0;
            load_err <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            tmo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_sync) begin
                        state    <= S_LOAD;
                        idx      <= '0;
                        sum      <= '0;
                        tmo      <= '0;
                        load_err <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        sum <= sum_next;
                        idx <= idx + AW'(1);
                        tmo <= '0;
                        if (idx == LAST_IDX) begin
                            state <= S_CHECK;
                        end
                    end else if (timed_out) begin
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                        loaded   <= 1'b0;
                        cpu_run  <= 1'b0;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end

                S_CHECK: begin
                    if (accept) begin
                        tmo <= '0;
                        if (sum_next == 8'h00) begin
                            state <= S_WAIT;
                        end else begin
                            state    <= S_ERROR;
                            load_err <= 1'b1;
                            loaded   <= 1'b0;
                            cpu_run  <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                        loaded   <= 1'b0;
                        cpu_run  <= 1'b0;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end

                S_WAIT: begin
                    state   <= S_RUN;
                    loaded  <= 1'b1;
                    cpu_run <= 1'b1;
                end

                S_RUN: begin
                    if (accept && is_sync) begin
                        state    <= S_LOAD;
                        cpu_run  <= 1'b0;
                        loaded   <= 1'b0;
                        load_err <= 1'b0;
                        idx      <= '0;
                        sum      <= '0;
                        tmo      <= '0;
                    end
                end

                S_ERROR: begin
                    cpu_run  <= 1'b0;
                    loaded   <= 1'b0;
                    if (accept && is_sync) begin
                        state    <= S_LOAD;
                        load_err <= 1'b0;
                        idx      <= '0;
                        sum      <= '0;
                        tmo      <= '0;
                    end else begin
                        load_err <= 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cpu_run  <= 1'b0;
                    loaded   <= 1'b0;
                    load_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized bench for prog_mem_loader against a frame-level model of the RAM image.
// Built with a short inter-byte timeout so the idle-abort path is quick to reach.
module tb_prog_mem_loader;

    localparam int         AW    = 6;
    localparam int         DEPTH = 64;
    localparam int         TMO   = 16;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] fetch_addr = '0;
    logic [7:0]    fetch_data;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          cpu_run;
    logic          loaded;
    logic          load_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_mem [DEPTH];
    logic [7:0] frame_buf [DEPTH];

    prog_mem_loader #(.AW(AW), .DW(8), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cpu_run    (cpu_run),
        .loaded     (loaded),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = 8'($urandom);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 4) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (!in_ready) check("ready_stall", int'(in_ready), 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    function automatic logic [7:0] non_sync_byte();
        logic [7:0] b = 8'($urandom);
        if (b == SYNC) b = 8'h3C;
        return b;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) frame_buf[i] = 8'($urandom);
    endtask

    // Streams frame_buf[0..n-1] with random gaps; the model image follows byte by byte.
    task automatic run_frame(input int n, output int s);
        s = 0;
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 3));
            put_byte(frame_buf[i]);
            model_mem[i] = frame_buf[i];
            s = (s + int'(frame_buf[i])) % 256;
            check("run_low_in_load", int'(cpu_run), 0);
        end
    endtask

    task automatic finish_frame(input int s, input int k_adj);
        int k;
        bit good;
        k = ((256 - s) % 256 + k_adj) % 256;
        good = ((s + k) % 256) == 0;
        idle($urandom_range(0, 3));
        put_byte(8'(k));
        if (good) begin
            check("wait_ready", int'(in_ready), 0);
            check("wait_run", int'(cpu_run), 0);
            @(posedge clock);
            #1;
            check("commit_loaded", int'(loaded), 1);
            check("commit_run", int'(cpu_run), 1);
            check("commit_err", int'(load_err), 0);
        end else begin
            check("bad_err", int'(load_err), 1);
            check("bad_run", int'(cpu_run), 0);
            check("bad_loaded", int'(loaded), 0);
            check("bad_ready", int'(in_ready), 1);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            fetch_addr = AW'(a);
            @(negedge clock);
            check(tag, int'(fetch_data), int'(model_mem[a]));
        end
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        put_byte(SYNC);
        check("sync_err_clr", int'(load_err), 0);
        check("sync_run_low", int'(cpu_run), 0);
    endtask

    task automatic good_load();
        int s;
        fill_random();
        start_frame();
        run_frame(DEPTH, s);
        finish_frame(s, 0);
    endtask

    initial begin
        int s;
        logic [7:0] old30;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_run", int'(cpu_run), 0);
        check("rst_loaded", int'(loaded), 0);
        check("rst_err", int'(load_err), 0);
        check("rst_ready", int'(in_ready), 1);

        // Non-sync bytes in IDLE are swallowed without effect.
        for (int i = 0; i < 4; i++) put_byte(non_sync_byte());
        check("idle_loaded", int'(loaded), 0);
        check("idle_ready", int'(in_ready), 1);

        // Test 1: ramp image i*3.
        for (int i = 0; i < DEPTH; i++) frame_buf[i] = 8'((i * 3) % 256);
        start_frame();
        run_frame(DEPTH, s);
        finish_frame(s, 0);
        fetch_addr = 6'd5;
        #1;
        check("fetch5", int'(fetch_data), 8'h0F);
        check_mem("mem_t1");

        // Test 2: same ramp with a wrong checksum, then recover.
        start_frame();
        run_frame(DEPTH, s);
        finish_frame(s, 1);
        idle(3);
        check("err_hold", int'(load_err), 1);
        good_load();
        check_mem("mem_t2");

        // Test 3: sync value inside the payload is ordinary data.
        fill_random();
        frame_buf[10] = SYNC;
        start_frame();
        run_frame(DEPTH, s);
        finish_frame(s, 0);
        fetch_addr = 6'd10;
        #1;
        check("mem10_sync", int'(fetch_data), int'(SYNC));
        check_mem("mem_t3");

        // Test 4: abandon a frame after 20 bytes and let the timer expire.
        fill_random();
        start_frame();
        run_frame(20, s);
        in_valid = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            @(posedge clock);
            #1;
            check("tmo_err", int'(load_err), int'(c == TMO));
        end
        check("tmo_run", int'(cpu_run), 0);
        check("tmo_loaded", int'(loaded), 0);
        check_mem("mem_t4");

        // Test 5: non-sync bytes in RUN ignored; sync drops the CPU and reloads.
        good_load();
        for (int i = 0; i < 5; i++) begin
            put_byte(non_sync_byte());
            check("run_hold", int'(cpu_run), 1);
            check("run_loaded", int'(loaded), 1);
        end
        check_mem("mem_t5a");
        put_byte(SYNC);
        check("resync_run", int'(cpu_run), 0);
        check("resync_loaded", int'(loaded), 0);
        fill_random();
        run_frame(DEPTH, s);
        finish_frame(s, 0);
        check_mem("mem_t5b");

        // Test 6: reset lands on the edge that would write byte 30.
        fill_random();
        start_frame();
        run_frame(30, s);
        old30 = model_mem[30];
        in_valid = 1'b1;
        in_data  = ~old30;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst6_run", int'(cpu_run), 0);
        check("rst6_loaded", int'(loaded), 0);
        check("rst6_err", int'(load_err), 0);
        check("rst6_ready", int'(in_ready), 1);
        fetch_addr = 6'd30;
        #1;
        check("rst6_mem30", int'(fetch_data), int'(old30));
        check_mem("mem_t6");
        for (int i = 0; i < 3; i++) put_byte(non_sync_byte());
        check("rst6_idle", int'(loaded), 0);
        good_load();
        check_mem("mem_t6b");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
